led_scan: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display, placed directly downstream of the hex-to-segment decoder. It takes the decoder's 32-bit segment word (four 8-bit patterns) and its flush/update flag, and holds the word in a tear-free shadow register. It scans one digit at a time onto a shared segment bus with per-digit enables, inserting a blanking interval at every digit change to suppress ghosting.

---
 rtl/led_scan_pkg.sv | 8 +
 rtl/led_scan_if.sv | 13 +
 rtl/led_scan_timer.sv | 41 ++++
 rtl/led_scan.sv | 67 ++++++
 tb/tb_led_scan.sv | 131 +++++++++++++
 5 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants and FSM state type for the seven-segment scan driver.
package led_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;
endpackage

// File: rtl/led_scan_if.sv
// Decoder-side word/flag in, display pins out.
interface led_scan_if;
  import led_pkg::*;

  logic [NUM_DIGITS*SEG_W-1:0] seg_in;
  logic                        update_en;
  logic [SEG_W-1:0]            seg;
  logic [NUM_DIGITS-1:0]       dig;
  logic                        frame_done;

  modport master (output seg_in, update_en, input seg, dig, frame_done);
  modport slave  (input seg_in, update_en, output seg, dig, frame_done);
endinterface

// File: rtl/led_scan_timer.sv
// Digit-slot timebase: cycle counter within a slot and the slot index.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] slot_o,
  output logic                          blank_end_o,
  output logic                          slot_end_o,
  output logic                          frame_end_o
);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int SLOT_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_end_o  = (cnt_q == CNT_W'(CLK_DIV - 1));
    // Last blank cycle of the slot; never asserted when there is no blanking.
    blank_end_o = (BLANK != 0) && (cnt_q == CNT_W'(BLANK - 1));
    frame_end_o = slot_end_o && (slot_q == SLOT_W'(NUM_DIGITS - 1));
    cnt_d       = slot_end_o ? '0 : cnt_q + 1'b1;
    slot_d      = slot_end_o ? slot_q + 1'b1 : slot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
endmodule

// File: rtl/led_scan.sv
// 4-digit multiplexed seven-segment driver with frame-synchronous shadow
// register and per-slot blanking to suppress ghosting.
module led_scan
  import led_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK      = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  led_scan_if.slave  bus
);
  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam state_e ST_RST = (BLANK == 0) ? ST_SHOW : ST_BLANK;

  logic [SLOT_W-1:0]           slot;
  logic                        blank_end, slot_end, frame_end;
  state_e                      state_q, state_d;
  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic [SEG_W-1:0]            seg_raw;
  logic [NUM_DIGITS-1:0]       dig_raw;

  led_scan_timer #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .slot_o      (slot),
    .blank_end_o (blank_end),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_BLANK: if (blank_end) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end && BLANK != 0) state_d = ST_BLANK;
      default:  state_d = ST_RST;
    endcase
    // Only the frame boundary may load a new image, so a frame never tears.
    if (frame_end && bus.update_en) shadow_d = bus.seg_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RST;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    seg_raw = SEG_BLANK;
    dig_raw = '0;
    if (state_q == ST_SHOW) begin
      dig_raw[slot] = 1'b1;
      seg_raw       = shadow_q[slot*SEG_W +: SEG_W];
    end
  end

  assign bus.seg        = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign bus.dig        = ACTIVE_LOW ? ~dig_raw : dig_raw;
  assign bus.frame_done = frame_end;
endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan: active-high and active-low instances share stimulus and
// are compared every cycle against a frame-position reference model.
module tb_led_scan;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic gclk = 1'b0;
  logic rst;
  always #5 gclk = ~gclk;

  led_scan_if if0 ();
  led_scan_if if1 ();

  led_scan #(.CLK_DIV(CLK_DIV), .BLANK(BLANK), .ACTIVE_LOW(1'b0)) u_dut0 (
    .clk (gclk), .rst (rst), .bus (if0.slave));
  led_scan #(.CLK_DIV(CLK_DIV), .BLANK(BLANK), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk (gclk), .rst (rst), .bus (if1.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference: position within the frame plus the image currently displayed.
  int          m_pos   = 0;
  logic [31:0] m_shadow = '0;
  bit          m_valid = 1'b0;

  always @(posedge gclk) begin
    if (rst) begin
      m_pos    <= 0;
      m_shadow <= '0;
      m_valid  <= 1'b1;
    end else begin
      if (m_pos == FRAME - 1 && if0.update_en) m_shadow <= if0.seg_in;
      m_pos <= (m_pos + 1) % FRAME;
    end
  end

  always @(negedge gclk) begin
    if (m_valid) begin
      int cnt, slot;
      logic [7:0] e_seg;
      logic [3:0] e_dig;
      cnt   = m_pos % CLK_DIV;
      slot  = m_pos / CLK_DIV;
      e_dig = (cnt < BLANK) ? 4'h0 : 4'(1 << slot);
      e_seg = (cnt < BLANK) ? 8'h00 : 8'((m_shadow >> (8 * slot)) & 32'hFF);
      chk("dig",      {28'd0, if0.dig}, {28'd0, e_dig});
      chk("seg",      {24'd0, if0.seg}, {24'd0, e_seg});
      chk("fdone",    {31'd0, if0.frame_done}, {31'd0, m_pos == FRAME - 1});
      chk("dig_n",    {28'd0, if1.dig}, {28'd0, ~e_dig});
      chk("seg_n",    {24'd0, if1.seg}, {24'd0, ~e_seg});
      chk("fdone_n",  {31'd0, if1.frame_done}, {31'd0, m_pos == FRAME - 1});
    end
  end

  task automatic drive(input logic [31:0] s, input logic u, input logic r);
    if0.seg_in = s; if0.update_en = u;
    if1.seg_in = s; if1.update_en = u;
    rst = r;
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic goto(input int p);
    for (int i = 0; i < 2 * FRAME && m_pos != p; i++) step();
    chk("goto", m_pos, p);
  endtask

  initial begin
    drive(32'h60DAF266, 1'b1, 1'b1);
    repeat (3) step();
    chk("rst_dig",   {28'd0, if0.dig}, 32'h0);
    chk("rst_seg",   {24'd0, if0.seg}, 32'h0);
    chk("rst_dig_n", {28'd0, if1.dig}, 32'hF);
    chk("rst_seg_n", {24'd0, if1.seg}, 32'hFF);
    rst = 1'b0;

    // Frame 0 shows the cleared shadow; boundary pulse on its last cycle.
    goto(10); chk("f0_seg", {24'd0, if0.seg}, 32'h00);
    goto(31); chk("f0_fdone", {31'd0, if0.frame_done}, 32'h1);
    step();
    chk("f1_c32_dig", {28'd0, if0.dig}, 32'h0);
    goto(2);
    chk("f1_s0_dig",   {28'd0, if0.dig}, 32'h1);
    chk("f1_s0_seg",   {24'd0, if0.seg}, 32'h66);
    chk("f1_s0_dig_n", {28'd0, if1.dig}, 32'hE);
    chk("f1_s0_seg_n", {24'd0, if1.seg}, 32'h99);
    goto(10); drive(32'hFCFCFCFC, 1'b0, 1'b0);
    goto(26);
    chk("f1_s3_dig", {28'd0, if0.dig}, 32'h8);
    chk("f1_s3_seg", {24'd0, if0.seg}, 32'h60);

    // Held image: frame 2 still shows the first word.
    goto(31); step(); goto(2);
    chk("hold_seg", {24'd0, if0.seg}, 32'h66);
    goto(10); drive(32'hFCFCFCFC, 1'b1, 1'b0);
    goto(18); chk("mid_seg", {24'd0, if0.seg}, 32'hDA);
    goto(31); step(); goto(2);
    chk("f3_seg", {24'd0, if0.seg}, 32'hFC);

    // Reset in slot 2, cnt 5.
    goto(21); rst = 1'b1; step();
    chk("mrst_dig", {28'd0, if0.dig}, 32'h0);
    chk("mrst_seg", {24'd0, if0.seg}, 32'h0);
    rst = 1'b0;
    goto(2);
    chk("mrst_f0_dig", {28'd0, if0.dig}, 32'h1);
    chk("mrst_f0_seg", {24'd0, if0.seg}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
      step();
    end
    rst = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
